// File: rtl/perf_pkg.sv
// Shared types for the performance counter unit: controller state encoding
// and the readback-select width helper.
package perf_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/perf_event_counter.sv
// Single increment-only counter with wrap or saturate behaviour and a sticky
// overflow flag raised whenever an increment is attempted from all-ones.
module perf_event_counter #(
    parameter int CNT_W = 32,
    parameter int SAT   = 0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt,
    output logic             ovf
);

    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (clr) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (inc) begin
            if (&cnt_q) begin
                ovf_q <= 1'b1;
                cnt_q <= (SAT != 0) ? cnt_q : '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/perf_counter_unit.sv
// Performance counter unit: one cycle counter plus N_EVT event counters,
// gated by an IDLE/RUN/HALT controller with an optional cycle limit.
module perf_counter_unit
    import perf_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int N_EVT = 4,
    parameter int SAT   = 0
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        start_i,
    input  logic                        clear_i,
    input  logic                        freeze_i,
    input  logic [N_EVT-1:0]            evt_i,
    input  logic [CNT_W-1:0]            limit_i,
    input  logic [sel_width(N_EVT)-1:0] sel_i,
    output logic [CNT_W-1:0]            cycle_o,
    output logic [CNT_W-1:0]            evt_cnt_o,
    output logic [N_EVT:0]              ovf_o,
    output logic                        done_o,
    output logic [STATE_W-1:0]          state_o
);

    state_e           state_q;
    logic             done_q;
    logic             count_en;
    logic             limit_hit;
    logic [CNT_W-1:0] cyc_cnt;
    logic [CNT_W-1:0] cyc_inc;
    logic             cyc_ovf;
    logic [CNT_W-1:0] evt_cnt [N_EVT];
    logic [N_EVT-1:0] evt_ovf;

    assign count_en = (state_q == ST_RUN) && !freeze_i && !clear_i;

    // Truncated increment: a wrap to 0 or a saturated counter never matches a
    // nonzero limit, so a limit at or below the current count is only reached
    // by wrapping around.
    assign cyc_inc   = cyc_cnt + CNT_W'(1);
    assign limit_hit = count_en && (limit_i != '0) && (cyc_inc == limit_i);

    perf_event_counter #(.CNT_W(CNT_W), .SAT(SAT)) u_cycle_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .inc   (count_en),
        .clr   (clear_i),
        .cnt   (cyc_cnt),
        .ovf   (cyc_ovf)
    );

    for (genvar k = 0; k < N_EVT; k++) begin : g_evt
        perf_event_counter #(.CNT_W(CNT_W), .SAT(SAT)) u_evt_cnt (
            .clk_i (clk_i),
            .rst_i (rst_i),
            .inc   (count_en && evt_i[k]),
            .clr   (clear_i),
            .cnt   (evt_cnt[k]),
            .ovf   (evt_ovf[k])
        );
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else if (clear_i) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            done_q <= limit_hit;
            case (state_q)
                ST_IDLE: if (start_i) state_q <= ST_RUN;
                ST_RUN: begin
                    if (limit_hit)     state_q <= ST_HALT;
                    else if (!start_i) state_q <= ST_IDLE;
                end
                ST_HALT: state_q <= ST_HALT;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        evt_cnt_o = '0;
        for (int k = 0; k < N_EVT; k++) begin
            if (int'(sel_i) == k) evt_cnt_o = evt_cnt[k];
        end
    end

    assign cycle_o = cyc_cnt;
    assign ovf_o   = {cyc_ovf, evt_ovf};
    assign done_o  = done_q;
    assign state_o = state_q;

endmodule
